sm_seq_multiplier: RTL

- Sequential shift-and-add multiplier for signed-magnitude operands; the inverse operation to the team's combinational signed-magnitude remainder/divide blocks.
- Produces a product in the same packed result format those blocks use: sign in the MSB, magnitude below it.
- Sits in the arithmetic unit beside the divide/remainder path and is driven by the ALU controller through a start/done handshake.

---
 rtl/sm_seq_multiplier.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sm_seq_multiplier.sv
// rtl/sm_seq_multiplier.sv - sequential shift-and-add signed-magnitude multiplier
module sm_seq_multiplier #(
  parameter int MAG_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MAG_W:0]     multiplicand,
  input  logic [MAG_W:0]     multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*MAG_W:0]   product,
  output logic               zero
);

  localparam int PROD_W = 2 * MAG_W;
  localparam int CNT_W  = (MAG_W > 1) ? $clog2(MAG_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAG_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q,  state_d;
  logic [MAG_W-1:0]    mcand_q,  mcand_d;
  logic [MAG_W-1:0]    mplier_q, mplier_d;
  logic                sign_q,   sign_d;
  logic [PROD_W-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]    count_q,  count_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;
  logic [PROD_W:0]     prod_q,   prod_d;
  logic                zero_q,   zero_d;

  logic [PROD_W-1:0]   addend;
  logic [PROD_W-1:0]   acc_sum;

  // Next-state and datapath: one partial product per RUN cycle; the result
  // registers are only written on the final step so no partial sum is visible.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    acc_d    = acc_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    prod_d   = prod_q;
    zero_d   = zero_q;

    addend  = mplier_q[0] ? (PROD_W'(mcand_q) << count_q) : '0;
    acc_sum = acc_q + addend;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = multiplicand[MAG_W-1:0];
          mplier_d = multiplier[MAG_W-1:0];
          sign_d   = multiplicand[MAG_W] ^ multiplier[MAG_W];
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          // A zero magnitude always reports +0, never -0.
          prod_d  = {sign_q && (acc_sum != '0), acc_sum};
          zero_d  = (acc_sum == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset that also aborts RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      prod_q   <= prod_d;
      zero_q   <= zero_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;
  assign zero    = zero_q;

endmodule
